// File: rtl/rom_loader_pkg.sv
// Shared types and default geometry for the Hack program ROM loader.
package rom_loader_pkg;

    localparam int unsigned DEFAULT_DEPTH  = 1024;
    localparam int unsigned DEFAULT_ADDR_W = 10;
    localparam int unsigned WORD_W         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

endpackage : rom_loader_pkg

// File: rtl/rom_loader.sv
// Streams a Hack program into the instruction ROM while holding the CPU in reset.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to treat the in_last word as a 16-bit checksum.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    // One extra counter bit so that "counter == DEPTH" is representable without wrapping.
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rom_we_q, rom_we_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [WORD_W-1:0]   rom_wdata_q, rom_wdata_d;
    logic                in_ready_q, in_ready_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;

    logic accept_c;
    logic full_c;
    logic write_c;
    logic enter_load_c;

    assign accept_c     = in_valid && in_ready_q && (state_q == LOAD);
    assign full_c       = (cnt_q == CNT_W'(DEPTH));
    assign enter_load_c = (state_q != LOAD) && (state_d == LOAD);

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_d;
    logic              sum_ok_c;

    assign sum_ok_c = (in_data == sum_q);
    // The checksum word itself is never written to the ROM.
    assign write_c  = accept_c && !in_last && !full_c;
`else
    assign write_c  = accept_c && !full_c;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept_c) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                    if (in_last) begin
                        state_d = sum_ok_c ? DONE : ERR;
                    end else if (full_c) begin
                        state_d = ERR;
                    end
`else
                    if (full_c) begin
                        state_d = ERR;
                    end else if (in_last) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; status outputs track the state being entered
    always_comb begin
        cnt_d       = cnt_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        in_ready_d  = (state_d == LOAD);
        cpu_reset_d = (state_d != DONE);
        load_done_d = (state_d == DONE);
        load_err_d  = (state_d == ERR);
`ifdef ROM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        if (enter_load_c) begin
            cnt_d = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_d = '0;
`endif
        end

        if (write_c) begin
            rom_we_d    = 1'b1;
            rom_addr_d  = cnt_q[ADDR_W-1:0];
            rom_wdata_d = in_data;
            cnt_d       = cnt_q + CNT_W'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_d       = sum_q + in_data;
`endif
        end
    end

    // Datapath and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q       <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            in_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            in_ready_q  <= in_ready_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign in_ready  = in_ready_q;
    assign cpu_reset = cpu_reset_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule : rom_loader

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader; checksum cases run when ROM_LOADER_CHECKSUM_EN is defined.
module tb_rom_loader;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 10;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic              in_last;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;

    int n_vec = 0;
    int n_err = 0;

    int          wr_a[$];
    logic [15:0] wr_d[$];
    logic [15:0] exp_d[$];

    rom_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 Clk = ~Clk;

    // Log every ROM write strobe mid-cycle
    always @(negedge Clk) begin
        if (rom_we === 1'b1) begin
            wr_a.push_back(int'(rom_addr));
            wr_d.push_back(rom_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Present one word and hold it until the loader accepts it (bounded)
    task automatic send_word(input string tag, input logic [15:0] d, input logic last);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 20; i++) begin
            acc = in_ready;
            tick(1);
            if (acc) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) chk({tag, "_accept_timeout"}, 32'(acc), 32'd1);
    endtask

    // Compare the writes logged since base against exp_d at addresses 0..n-1
    task automatic chk_writes(input string tag, input int base);
        chk({tag, "_nwrites"}, 32'(wr_a.size() - base), 32'(exp_d.size()));
        for (int k = 0; k < exp_d.size(); k++) begin
            if (base + k < wr_a.size()) begin
                chk({tag, "_addr"}, 32'(wr_a[base+k]), 32'(k));
                chk({tag, "_data"}, 32'(wr_d[base+k]), 32'(exp_d[k]));
            end
        end
    endtask

    initial begin
        int base;
        int bad;
        int zeros;

        Reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        in_last  = 1'b0;
        tick(2);
        Reset = 1'b0;

        // Reset state
        chk("rst_rom_we",    32'(rom_we),    32'd0);
        chk("rst_rom_addr",  32'(rom_addr),  32'd0);
        chk("rst_rom_wdata", 32'(rom_wdata), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_err",  32'(load_err),  32'd0);
        tick(2);
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // Basic three-word program
        base = wr_a.size();
        pulse_start();
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        chk("t1_cpu_reset_loading", 32'(cpu_reset), 32'd1);
        send_word("t1w0", 16'h0010, 1'b0);
        send_word("t1w1", 16'hEC10, 1'b0);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_word("t1w2", 16'h0011, 1'b0);
        send_word("t1ck", 16'hEC31, 1'b1);
`else
        send_word("t1w2", 16'h0011, 1'b1);
`endif
        tick(3);
        exp_d = '{16'h0010, 16'hEC10, 16'h0011};
        chk_writes("t1", base);
        chk("t1_load_done", 32'(load_done), 32'd1);
        chk("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("t1_in_ready_done", 32'(in_ready), 32'd0);
        chk("t1_load_err", 32'(load_err), 32'd0);

        // Restart from DONE with in_valid toggling; stray start mid-load is ignored
        base = wr_a.size();
        pulse_start();
        chk("t2_cpu_reset_reassert", 32'(cpu_reset), 32'd1);
        chk("t2_load_done_clear", 32'(load_done), 32'd0);
        send_word("t2w0", 16'h1000, 1'b0);
        tick(1);
        send_word("t2w1", 16'h1001, 1'b0);
        pulse_start();
        send_word("t2w2", 16'h1002, 1'b0);
        tick(1);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_word("t2w3", 16'h1003, 1'b0);
        tick(1);
        send_word("t2ck", 16'h4006, 1'b1);
`else
        send_word("t2w3", 16'h1003, 1'b1);
`endif
        tick(3);
        exp_d = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
        chk_writes("t2", base);
        chk("t2_load_done", 32'(load_done), 32'd1);

        // Reset mid-load after 5 of 10 words; the 6th word's handshake is dropped
        base = wr_a.size();
        pulse_start();
        for (int i = 0; i < 5; i++) send_word("t3w", 16'h2000 + 16'(i), 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h2005;
        Reset    = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("t3_rst_rom_we", 32'(rom_we), 32'd0);
        chk("t3_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t3_rst_in_ready", 32'(in_ready), 32'd0);
        tick(1);
        Reset = 1'b0;
        tick(3);
        exp_d = '{16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h2004};
        chk_writes("t3", base);
        chk("t3_idle_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t3_idle_load_done", 32'(load_done), 32'd0);

        base = wr_a.size();
        pulse_start();
        send_word("t3r0", 16'h3000, 1'b0);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_word("t3r1", 16'h3001, 1'b0);
        send_word("t3ck", 16'h6001, 1'b1);
`else
        send_word("t3r1", 16'h3001, 1'b1);
`endif
        tick(3);
        exp_d = '{16'h3000, 16'h3001};
        chk_writes("t3r", base);
        chk("t3r_load_done", 32'(load_done), 32'd1);

        // Overflow: 1025 words without last
        base = wr_a.size();
        pulse_start();
        for (int i = 0; i < DEPTH + 1; i++) send_word("t4w", 16'(i) ^ 16'h5A00, 1'b0);
        tick(3);
        chk("t4_nwrites", 32'(wr_a.size() - base), 32'(DEPTH));
        bad   = 0;
        zeros = 0;
        for (int k = 0; k < wr_a.size() - base; k++) begin
            if (wr_a[base+k] != k || wr_d[base+k] != (16'(k) ^ 16'h5A00)) bad++;
            if (wr_a[base+k] == 0) zeros++;
        end
        chk("t4_seq_errors", 32'(bad), 32'd0);
        chk("t4_addr0_writes", 32'(zeros), 32'd1);
        chk("t4_last_addr", 32'(wr_a[wr_a.size()-1]), 32'(DEPTH - 1));
        chk("t4_load_err", 32'(load_err), 32'd1);
        chk("t4_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t4_in_ready", 32'(in_ready), 32'd0);
        chk("t4_load_done", 32'(load_done), 32'd0);

        // Restart from ERR clears load_err
        base = wr_a.size();
        pulse_start();
        chk("t5_load_err_clear", 32'(load_err), 32'd0);
        chk("t5_cpu_reset", 32'(cpu_reset), 32'd1);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_word("t5w0", 16'h0001, 1'b0);
        send_word("t5w1", 16'h0002, 1'b0);
        send_word("t5ck", 16'h0003, 1'b1);
        tick(3);
        exp_d = '{16'h0001, 16'h0002};
        chk_writes("t5", base);
        chk("t5_load_done", 32'(load_done), 32'd1);
        chk("t5_load_err", 32'(load_err), 32'd0);

        base = wr_a.size();
        pulse_start();
        send_word("t6w0", 16'h0001, 1'b0);
        send_word("t6w1", 16'h0002, 1'b0);
        send_word("t6ck", 16'h0004, 1'b1);
        tick(3);
        exp_d = '{16'h0001, 16'h0002};
        chk_writes("t6", base);
        chk("t6_load_err", 32'(load_err), 32'd1);
        chk("t6_load_done", 32'(load_done), 32'd0);
        chk("t6_cpu_reset", 32'(cpu_reset), 32'd1);
`else
        send_word("t5w0", 16'h0001, 1'b1);
        tick(3);
        exp_d = '{16'h0001};
        chk_writes("t5", base);
        chk("t5_load_done", 32'(load_done), 32'd1);
        chk("t5_load_err", 32'(load_err), 32'd0);
        chk("t5_cpu_reset", 32'(cpu_reset), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rom_loader
